alu_sequencer: RTL

Multi-cycle controller that sits on the opposite side of the ALU's operand/opcode/flag interface. It accepts 8-bit instructions over a valid/ready handshake and reads two operands from an internal 4-entry register file. It drives the ALU's dst, src, ALU_OP and CF inputs, then captures F and FLAG. It writes F back to the register file and holds the PSW (S,Z,O,C) whose C bit feeds the ALU's CF input.

---
 rtl/alu_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller that feeds an external ALU from a
// 4-entry register file and writes the ALU result and flags back.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for an instruction; register preload allowed
// READ  | register file read into the ALU operand/opcode registers
// EXEC  | ALU result captured; PSW updated for legal non-NOP ops
// WB    | result written to R[dst]; done (and err if illegal) high
module alu_sequencer #(
  parameter int DATAWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [7:0]           instr,
  input  logic                 reg_we,
  input  logic [1:0]           reg_waddr,
  input  logic [DATAWIDTH-1:0] reg_wdata,
  input  logic [1:0]           rd_addr,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic [DATAWIDTH-1:0] alu_dst,
  output logic [DATAWIDTH-1:0] alu_src,
  output logic [3:0]           alu_op,
  output logic                 alu_cf,
  input  logic [DATAWIDTH-1:0] alu_f,
  input  logic [3:0]           alu_flag,
  output logic [3:0]           psw,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           op_q;
  logic [1:0]           dst_idx;
  logic [1:0]           src_idx;
  logic [DATAWIDTH-1:0] regs [4];
  logic [DATAWIDTH-1:0] result;
  logic                 accept;
  logic                 legal;
  logic                 writes;

  assign accept  = instr_valid & instr_ready;
  // Opcodes 11..15 are illegal; NOP and illegal ops leave R and PSW alone.
  assign legal   = (op_q <= 4'd10);
  assign writes  = legal && (op_q != 4'd0);
  assign rd_data = regs[rd_addr];
  assign alu_cf  = psw[0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded handshake/status outputs.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        err       = ~legal;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the instruction fields on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 4'd0;
      dst_idx <= 2'd0;
      src_idx <= 2'd0;
    end else if (accept) begin
      op_q    <= instr[7:4];
      dst_idx <= instr[3:2];
      src_idx <= instr[1:0];
    end
  end

  // Drive the ALU operands and opcode from the register file during READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_dst <= '0;
      alu_src <= '0;
      alu_op  <= 4'd0;
    end else if (state == READ) begin
      alu_dst <= regs[dst_idx];
      alu_src <= regs[src_idx];
      alu_op  <= legal ? op_q : 4'd0;
    end
  end

  // Capture the ALU result and flags at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      psw    <= 4'd0;
    end else if (state == EXEC) begin
      result <= alu_f;
      if (writes) psw <= alu_flag;
    end
  end

  // Register file: preload only in IDLE, writeback only in WB, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if ((state == IDLE) && reg_we) begin
      regs[reg_waddr] <= reg_wdata;
    end else if ((state == WB) && writes) begin
      regs[dst_idx] <= result;
    end
  end

endmodule
